hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Parametrised pipeline hazard unit for the 5-stage RISC-V core. Successor to the stall-only hazard
//  logic: adds EX-operand forwarding, single-bubble load-use stall, branch-redirect flush with
//  programmable squash window, and a memory-wait FSM with watchdog. Drives per-stage clock enables,
//  flush strobes and forwarding selects.
// PARAMETERS
//  REG_AW        5   register-address width
//  FLUSH_CYCLES  1   extra cycles IF/ID is squashed after a redirect (0..15; 0 = same-cycle only)
//  MEM_TIMEOUT   256 consecutive !i_data_ready cycles before o_mem_timeout sets (>=2)
//  CNT_W         32  perf-counter width (used only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk               in   1       core clock
//  rst               in   1       synchronous reset, active-high
//  i_instr_ready     in   1       instruction memory ready
//  i_data_ready      in   1       data memory ready
//  i_id_rs1/rs2      in   REG_AW  ID-stage source registers
//  i_id_rs1_used/rs2_used in 1    ID source actually read
//  i_ex_rs1/rs2      in   REG_AW  EX-stage source registers (forwarding compare)
//  i_ex_rd, i_ex_reg_wr, i_ex_is_load  in  REG_AW,1,1  EX destination info
//  i_ma_rd, i_ma_reg_wr  in  REG_AW,1   MA destination
//  i_wb_rd, i_wb_reg_wr  in  REG_AW,1   WB destination
//  i_ex_branch_taken in   1       branch/jump resolved taken in EX
//  o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_ma_clk_en  out 1  stage enables
//  o_id_flush        out  1       clear IF/ID register (kill fetched instr)
//  o_ex_flush        out  1       load bubble into ID/EX register
//  o_fwd_rs1_sel/rs2_sel out 2    00 regfile, 01 from MA, 10 from WB
//  o_mem_timeout     out  1       sticky watchdog flag
// BEHAVIOUR
//  - Reset (rst=1): FSM->HZ_RUN, counters 0, o_mem_timeout 0; outputs during rst: all clk_en=1,
//    o_id_flush=o_ex_flush=1, fwd selects 00.
//  - Forwarding (combinational): per EX source, rs==0 ->00; match MA rd & wr ->01 (priority); else
//    match WB rd & wr ->10; else 00. Computed independent of stall state.
//  - Load-use: used ID source !=0, ==i_ex_rd, i_ex_reg_wr & i_ex_is_load -> one cycle: IF/ID enables 0,
//    o_ex_flush=1, EX/MA enables 1. Next cycle EX holds bubble so condition self-clears.
//  - Instr wait: !i_instr_ready alone -> IF/ID enables 0, o_ex_flush=1; EX/MA proceed.
//  - FSM HZ_RUN/HZ_FLUSH/HZ_MEM_WAIT; priority per cycle: data wait > branch > load-use > instr wait.
//  - !i_data_ready: all four enables 0, no flushes; state HZ_MEM_WAIT until ready, then return to the
//    state held before (HZ_RUN or HZ_FLUSH with counter frozen). Taken branch seen while frozen is
//    acted on the first ready cycle (branch still in EX).
//  - Taken branch (HZ_RUN or HZ_FLUSH): same cycle o_id_flush=o_ex_flush=1, all enables 1; if
//    FLUSH_CYCLES>0 enter HZ_FLUSH, counter=FLUSH_CYCLES. HZ_FLUSH: o_id_flush=1, decrement per
//    non-frozen cycle, exit to HZ_RUN at 0. New taken branch in HZ_FLUSH reloads counter.
//  - Branch + load-use same cycle: flush only, no stall. Load-use suppressed in HZ_FLUSH (ID squashed).
//  - Watchdog: consecutive-!i_data_ready counter saturates; at MEM_TIMEOUT sets o_mem_timeout,
//    cleared only by rst. Counter clears on any ready cycle.
//  - Reset mid-stall/flush: next cycle HZ_RUN, all counters 0.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs o_cnt_load_use, o_cnt_flush, o_cnt_mem_wait [CNT_W-1:0];
//  each increments once per cycle its cause owns the pipeline (after priority), saturating at max,
//  zero on rst. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  hazard_pkg: hz_state_e {HZ_RUN, HZ_FLUSH, HZ_MEM_WAIT}; fwd_sel_e {FWD_RF=2'b00, FWD_MA=2'b01,
//  FWD_WB=2'b10}. Sub-module hazard_fwd_sel (one source -> fwd_sel_e), instantiated for rs1 and rs2.
// TESTING
//  1 EX rs1=x5, MA rd=x5 wr=1, WB rd=x5 wr=1 -> o_fwd_rs1_sel=01; MA wr=0 -> 10; rs1=x0 -> 00.
//  2 EX lw x7, ID add uses rs2=x7 -> 1 cycle IF/ID en=0, o_ex_flush=1; next cycle normal.
//  3 FLUSH_CYCLES=2, taken branch -> cycle0 both flushes=1, cycles1-2 o_id_flush=1, cycle3 HZ_RUN.
//  4 i_data_ready=0 for 3 cycles with branch taken -> all en=0, no flush; ready -> flush that cycle.
//  5 MEM_TIMEOUT=4, i_data_ready=0 for 4 cycles -> o_mem_timeout=1 at cycle 4, stays 1 until rst.
//  6 rst asserted during HZ_FLUSH -> next cycle HZ_RUN, perf counters (if enabled) read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: FSM state encoding and
// forwarding-select encoding, plus the squash-window counter width.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_FLUSH    = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_MA = 2'b01,
    FWD_WB = 2'b10
  } fwd_sel_e;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side signal bundle of the hazard unit; the core drives the i_* side
// (master) and the hazard unit returns enables, flushes and forwarding selects (slave).
interface hazard_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
);
  logic              i_instr_ready;
  logic              i_data_ready;
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic              i_id_rs1_used;
  logic              i_id_rs2_used;
  logic [REG_AW-1:0] i_ex_rs1;
  logic [REG_AW-1:0] i_ex_rs2;
  logic [REG_AW-1:0] i_ex_rd;
  logic              i_ex_reg_wr;
  logic              i_ex_is_load;
  logic [REG_AW-1:0] i_ma_rd;
  logic              i_ma_reg_wr;
  logic [REG_AW-1:0] i_wb_rd;
  logic              i_wb_reg_wr;
  logic              i_ex_branch_taken;
  logic              o_if_clk_en;
  logic              o_id_clk_en;
  logic              o_ex_clk_en;
  logic              o_ma_clk_en;
  logic              o_id_flush;
  logic              o_ex_flush;
  fwd_sel_e          o_fwd_rs1_sel;
  fwd_sel_e          o_fwd_rs2_sel;
  logic              o_mem_timeout;

  modport master (
    output i_instr_ready, i_data_ready, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_reg_wr, i_ex_is_load, i_ma_rd, i_ma_reg_wr,
           i_wb_rd, i_wb_reg_wr, i_ex_branch_taken,
    input  o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_ma_clk_en, o_id_flush, o_ex_flush,
           o_fwd_rs1_sel, o_fwd_rs2_sel, o_mem_timeout
  );

  modport slave (
    input  i_instr_ready, i_data_ready, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_reg_wr, i_ex_is_load, i_ma_rd, i_ma_reg_wr,
           i_wb_rd, i_wb_reg_wr, i_ex_branch_taken,
    output o_if_clk_en, o_id_clk_en, o_ex_clk_en, o_ma_clk_en, o_id_flush, o_ex_flush,
           o_fwd_rs1_sel, o_fwd_rs2_sel, o_mem_timeout
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX source operand: the younger MA result wins over WB,
// and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_ma_rd,
  input  logic              i_ma_reg_wr,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_reg_wr,
  output fwd_sel_e          o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_rs != '0) begin
      if (i_ma_reg_wr && (i_ma_rd == i_rs)) begin
        o_sel = FWD_MA;
      end else if (i_wb_reg_wr && (i_wb_rd == i_rs)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use bubble, branch squash window and data-memory
// wait with watchdog. Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
//
// state       | meaning
// HZ_RUN      | normal flow; load-use and instruction-wait stalls may apply
// HZ_FLUSH    | post-redirect squash window, IF/ID cleared while flush_cnt counts down
// HZ_MEM_WAIT | data memory not ready, whole pipe frozen; resumes RUN or FLUSH
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 256,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_if.slave          bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt_load_use,
  output logic [CNT_W-1:0] o_cnt_flush,
  output logic [CNT_W-1:0] o_cnt_mem_wait
`endif
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  if (FLUSH_CYCLES > 15 || MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_params
    $fatal(1, "hazard_unit: parameter out of range");
  end

  hz_state_e              state_q, state_d, eff_state;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   load_use;
  logic                   if_en, id_en, ex_en, ma_en, id_flush, ex_flush;
  fwd_sel_e               fwd_rs1, fwd_rs2;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .i_rs(bus.i_ex_rs1), .i_ma_rd(bus.i_ma_rd), .i_ma_reg_wr(bus.i_ma_reg_wr),
    .i_wb_rd(bus.i_wb_rd), .i_wb_reg_wr(bus.i_wb_reg_wr), .o_sel(fwd_rs1)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .i_rs(bus.i_ex_rs2), .i_ma_rd(bus.i_ma_rd), .i_ma_reg_wr(bus.i_ma_reg_wr),
    .i_wb_rd(bus.i_wb_rd), .i_wb_reg_wr(bus.i_wb_reg_wr), .o_sel(fwd_rs2)
  );

  assign load_use = bus.i_ex_reg_wr && bus.i_ex_is_load &&
                    ((bus.i_id_rs1_used && (bus.i_id_rs1 != '0) && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                     (bus.i_id_rs2_used && (bus.i_id_rs2 != '0) && (bus.i_id_rs2 == bus.i_ex_rd)));

  // A non-zero squash counter only exists inside the flush window, so it also
  // records which state a memory wait has to resume into.
  always_comb begin
    eff_state = state_q;
    if (state_q == HZ_MEM_WAIT) begin
      eff_state = (flush_cnt_q != '0) ? HZ_FLUSH : HZ_RUN;
    end
  end

  always_comb begin
    state_d     = eff_state;
    flush_cnt_d = flush_cnt_q;
    if_en       = 1'b1;
    id_en       = 1'b1;
    ex_en       = 1'b1;
    ma_en       = 1'b1;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    if (!bus.i_data_ready) begin
      if_en   = 1'b0;
      id_en   = 1'b0;
      ex_en   = 1'b0;
      ma_en   = 1'b0;
      state_d = HZ_MEM_WAIT;
    end else if (bus.i_ex_branch_taken) begin
      id_flush = 1'b1;
      ex_flush = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_d     = HZ_FLUSH;
        flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES);
      end else begin
        state_d = HZ_RUN;
      end
    end else if (eff_state == HZ_FLUSH) begin
      id_flush    = 1'b1;
      flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
      if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
        state_d = HZ_RUN;
      end
      if (!bus.i_instr_ready) begin
        if_en    = 1'b0;
        id_en    = 1'b0;
        ex_flush = 1'b1;
      end
    end else if (load_use || !bus.i_instr_ready) begin
      if_en    = 1'b0;
      id_en    = 1'b0;
      ex_flush = 1'b1;
    end
  end

  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = timeout_q;
    if (!bus.i_data_ready) begin
      wd_cnt_d = (wd_cnt_q == WD_W'(MEM_TIMEOUT)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
      if (wd_cnt_d == WD_W'(MEM_TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HZ_RUN;
      flush_cnt_q <= '0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.o_if_clk_en   = rst | if_en;
  assign bus.o_id_clk_en   = rst | id_en;
  assign bus.o_ex_clk_en   = rst | ex_en;
  assign bus.o_ma_clk_en   = rst | ma_en;
  assign bus.o_id_flush    = rst | id_flush;
  assign bus.o_ex_flush    = rst | ex_flush;
  assign bus.o_fwd_rs1_sel = rst ? FWD_RF : fwd_rs1;
  assign bus.o_fwd_rs2_sel = rst ? FWD_RF : fwd_rs2;
  assign bus.o_mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic             own_lu, own_fl, own_mw;
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d, cnt_fl_q, cnt_fl_d, cnt_mw_q, cnt_mw_d;

  // Each cycle is charged to at most one cause, following the stall priority.
  assign own_mw = !bus.i_data_ready;
  assign own_fl = bus.i_data_ready && (bus.i_ex_branch_taken || (eff_state == HZ_FLUSH));
  assign own_lu = bus.i_data_ready && !bus.i_ex_branch_taken && (eff_state != HZ_FLUSH) && load_use;

  always_comb begin
    cnt_lu_d = cnt_lu_q;
    cnt_fl_d = cnt_fl_q;
    cnt_mw_d = cnt_mw_q;
    if (own_lu && (cnt_lu_q != '1)) cnt_lu_d = cnt_lu_q + CNT_W'(1);
    if (own_fl && (cnt_fl_q != '1)) cnt_fl_d = cnt_fl_q + CNT_W'(1);
    if (own_mw && (cnt_mw_q != '1)) cnt_mw_d = cnt_mw_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu_q <= '0;
      cnt_fl_q <= '0;
      cnt_mw_q <= '0;
    end else begin
      cnt_lu_q <= cnt_lu_d;
      cnt_fl_q <= cnt_fl_d;
      cnt_mw_q <= cnt_mw_d;
    end
  end

  assign o_cnt_load_use = cnt_lu_q;
  assign o_cnt_flush    = cnt_fl_q;
  assign o_cnt_mem_wait = cnt_mw_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus randomized bench for hazard_unit against a cycle-level behavioural
// model built from the pipeline rules (squash cycles remaining, consecutive wait cycles).
module tb_hazard_unit;

  localparam int FC = 2;
  localparam int MT = 4;

  logic clk;
  logic rst;

  hazard_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_lu, cnt_fl, cnt_mw;
`endif

  hazard_unit #(.REG_AW(5), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_cnt_load_use(cnt_lu),
    .o_cnt_flush(cnt_fl),
    .o_cnt_mem_wait(cnt_mw)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_sq  = 0;   // squash cycles still owed after a redirect
  int m_dry = 0;   // consecutive data-not-ready cycles
  bit m_tmo = 0;
  int m_lu = 0, m_fl = 0, m_mw = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd_ref(int rs, int ma_rd, bit ma_wr, int wb_rd, bit wb_wr);
    if (rs == 0) return 0;
    if (ma_wr && ma_rd == rs) return 1;
    if (wb_wr && wb_rd == rs) return 2;
    return 0;
  endfunction

  function automatic bit lu_ref();
    bit hit1, hit2;
    hit1 = bus.i_id_rs1_used && bus.i_id_rs1 != 0 && bus.i_id_rs1 == bus.i_ex_rd;
    hit2 = bus.i_id_rs2_used && bus.i_id_rs2 != 0 && bus.i_id_rs2 == bus.i_ex_rd;
    return (hit1 || hit2) && bus.i_ex_reg_wr && bus.i_ex_is_load;
  endfunction

  function automatic logic [3:0] en_obs();
    return {bus.o_if_clk_en, bus.o_id_clk_en, bus.o_ex_clk_en, bus.o_ma_clk_en};
  endfunction

  function automatic logic [1:0] fl_obs();
    return {bus.o_id_flush, bus.o_ex_flush};
  endfunction

  task automatic check_now();
    logic [3:0] en;
    logic [1:0] fl;
    int f1, f2;
    #1;
    en = 4'hf; fl = 2'b00;
    f1 = fwd_ref(int'(bus.i_ex_rs1), int'(bus.i_ma_rd), bus.i_ma_reg_wr, int'(bus.i_wb_rd), bus.i_wb_reg_wr);
    f2 = fwd_ref(int'(bus.i_ex_rs2), int'(bus.i_ma_rd), bus.i_ma_reg_wr, int'(bus.i_wb_rd), bus.i_wb_reg_wr);
    if (rst) begin
      fl = 2'b11; f1 = 0; f2 = 0;
    end else if (!bus.i_data_ready) begin
      en = 4'h0;
    end else if (bus.i_ex_branch_taken) begin
      fl = 2'b11;
    end else if (m_sq > 0) begin
      fl = 2'b10;
      if (!bus.i_instr_ready) begin en = 4'b0011; fl = 2'b11; end
    end else if (lu_ref() || !bus.i_instr_ready) begin
      en = 4'b0011; fl = 2'b01;
    end
    chk("enables", 32'(en_obs()), 32'(en));
    chk("flushes", 32'(fl_obs()), 32'(fl));
    chk("fwd_rs1", 32'(bus.o_fwd_rs1_sel), 32'(f1));
    chk("fwd_rs2", 32'(bus.o_fwd_rs2_sel), 32'(f2));
    chk("mem_timeout", 32'(bus.o_mem_timeout), 32'(m_tmo));
`ifdef HAZARD_PERF_CNT_EN
    chk("cnt_load_use", cnt_lu, 32'(m_lu));
    chk("cnt_flush", cnt_fl, 32'(m_fl));
    chk("cnt_mem_wait", cnt_mw, 32'(m_mw));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_sq = 0; m_dry = 0; m_tmo = 0; m_lu = 0; m_fl = 0; m_mw = 0;
    end else if (!bus.i_data_ready) begin
      m_mw++;
      m_dry = (m_dry < MT) ? m_dry + 1 : MT;
      if (m_dry == MT) m_tmo = 1;
    end else begin
      m_dry = 0;
      if (bus.i_ex_branch_taken || m_sq > 0) m_fl++;
      else if (lu_ref()) m_lu++;
      if (bus.i_ex_branch_taken) m_sq = FC;
      else if (m_sq > 0) m_sq--;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.i_instr_ready = 1'b1; bus.i_data_ready = 1'b1;
    bus.i_id_rs1 = '0; bus.i_id_rs2 = '0; bus.i_id_rs1_used = 1'b0; bus.i_id_rs2_used = 1'b0;
    bus.i_ex_rs1 = '0; bus.i_ex_rs2 = '0; bus.i_ex_rd = '0; bus.i_ex_reg_wr = 1'b0;
    bus.i_ex_is_load = 1'b0; bus.i_ma_rd = '0; bus.i_ma_reg_wr = 1'b0;
    bus.i_wb_rd = '0; bus.i_wb_reg_wr = 1'b0; bus.i_ex_branch_taken = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    check_now();
    chk("reset_en", 32'(en_obs()), 32'hf);
    chk("reset_flush", 32'(fl_obs()), 32'h3);
    tick();

    // forwarding priority
    idle();
    bus.i_ex_rs1 = 5'd5; bus.i_ma_rd = 5'd5; bus.i_ma_reg_wr = 1'b1;
    bus.i_wb_rd = 5'd5; bus.i_wb_reg_wr = 1'b1;
    check_now(); chk("t1_ma", 32'(bus.o_fwd_rs1_sel), 32'd1); tick();
    bus.i_ma_reg_wr = 1'b0;
    check_now(); chk("t1_wb", 32'(bus.o_fwd_rs1_sel), 32'd2); tick();
    bus.i_ex_rs1 = 5'd0;
    check_now(); chk("t1_x0", 32'(bus.o_fwd_rs1_sel), 32'd0); tick();

    // load-use bubble
    idle();
    bus.i_ex_rd = 5'd7; bus.i_ex_reg_wr = 1'b1; bus.i_ex_is_load = 1'b1;
    bus.i_id_rs2 = 5'd7; bus.i_id_rs2_used = 1'b1;
    check_now();
    chk("t2_stall_en", 32'(en_obs()), 32'b0011);
    chk("t2_bubble", 32'(bus.o_ex_flush), 32'd1);
    tick();
    bus.i_ex_reg_wr = 1'b0; bus.i_ex_is_load = 1'b0;
    check_now(); chk("t2_resume", 32'(en_obs()), 32'hf); tick();

    // branch squash window
    idle();
    bus.i_ex_branch_taken = 1'b1;
    check_now(); chk("t3_c0", 32'(fl_obs()), 32'b11); tick();
    bus.i_ex_branch_taken = 1'b0;
    for (int c = 1; c <= FC; c++) begin
      check_now(); chk("t3_window", 32'(fl_obs()), 32'b10); tick();
    end
    check_now(); chk("t3_run", 32'(fl_obs()), 32'b00); tick();

    // branch held across a data wait
    idle();
    bus.i_data_ready = 1'b0; bus.i_ex_branch_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_now(); chk("t4_frozen", 32'({en_obs(), fl_obs()}), 32'd0); tick();
    end
    bus.i_data_ready = 1'b1;
    check_now(); chk("t4_go", 32'(fl_obs()), 32'b11); tick();
    idle();
    for (int c = 0; c < 3; c++) begin check_now(); tick(); end

    // watchdog
    idle();
    bus.i_data_ready = 1'b0;
    for (int c = 0; c < MT; c++) begin
      check_now(); chk("t5_clear", 32'(bus.o_mem_timeout), 32'd0); tick();
    end
    check_now(); chk("t5_set", 32'(bus.o_mem_timeout), 32'd1); tick();
    bus.i_data_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_now(); chk("t5_sticky", 32'(bus.o_mem_timeout), 32'd1); tick();
    end

    // reset in the middle of a squash window
    rst = 1'b1; check_now(); tick();
    idle(); bus.i_ex_branch_taken = 1'b1; check_now(); tick();
    bus.i_ex_branch_taken = 1'b0;
    check_now(); chk("t6_in_flush", 32'(fl_obs()), 32'b10); tick();
    rst = 1'b1; check_now(); tick();
    rst = 1'b0;
    check_now();
    chk("t6_run", 32'(fl_obs()), 32'b00);
    chk("t6_tmo", 32'(bus.o_mem_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("t6_cnt", cnt_lu | cnt_fl | cnt_mw, 32'd0);
`endif
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst                   = ($urandom_range(0, 99) == 0);
      bus.i_data_ready      = ($urandom_range(0, 99) >= 12);
      bus.i_instr_ready     = ($urandom_range(0, 99) >= 15);
      bus.i_ex_branch_taken = ($urandom_range(0, 99) < 12);
      bus.i_id_rs1          = 5'($urandom_range(0, 7));
      bus.i_id_rs2          = 5'($urandom_range(0, 7));
      bus.i_id_rs1_used     = 1'($urandom);
      bus.i_id_rs2_used     = 1'($urandom);
      bus.i_ex_rs1          = 5'($urandom_range(0, 7));
      bus.i_ex_rs2          = 5'($urandom_range(0, 7));
      bus.i_ex_rd           = 5'($urandom_range(0, 7));
      bus.i_ex_reg_wr       = 1'($urandom);
      bus.i_ex_is_load      = 1'($urandom);
      bus.i_ma_rd           = 5'($urandom_range(0, 7));
      bus.i_ma_reg_wr       = 1'($urandom);
      bus.i_wb_rd           = 5'($urandom_range(0, 7));
      bus.i_wb_reg_wr       = 1'($urandom);
      check_now();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
